// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: issues imem fetches, squashes stale responses on redirect,
// and holds each fetched instruction until decode accepts it.
module pc_fetch_ctrl #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             imem_req,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [Width-1:0] instr_pc,
  input  logic             instr_ready,
  output logic [Width-1:0] PC,
  output logic [Width-1:0] PCPlus4
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  localparam logic [Width-1:0] Four = Width'(4);

  state_e           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             ivalid_q, ivalid_d;
  logic [31:0]      instr_q, instr_d;
  logic [Width-1:0] ipc_q, ipc_d;
  logic [Width-1:0] tgt;

  assign tgt       = {redirect_pc[Width-1:2], 2'b00};
  assign PC        = pc_q;
  assign PCPlus4   = pc_q + Four;
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;

  assign instr_valid = ivalid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_d  = flush_q;
    ivalid_d = ivalid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    unique case (state_q)
      S_IDLE: begin
        if (!stall) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          // granted fetch used the old PC
          flush_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (flush_q || redirect_valid) begin
            flush_d = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d  = imem_rdata;
            ipc_d    = pc_q;
            ivalid_d = 1'b1;
            pc_d     = PCPlus4;
            state_d  = S_HOLD;
          end
        end else if (redirect_valid) begin
          flush_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          ivalid_d = 1'b0;
          state_d  = S_REQ;
        end else if (instr_ready) begin
          ivalid_d = 1'b0;
          state_d  = stall ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) pc_d = tgt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      flush_q  <= 1'b0;
      ivalid_q <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      ivalid_q <= ivalid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized bench for pc_fetch_ctrl with an
// instruction-level model of the fetch/hold protocol.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, pc, pc_plus4;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(.Width(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .PC(pc), .PCPlus4(pc_plus4)
  );

  always #5 clk = ~clk;

  // Model: a request is pending, a fetch is outstanding (maybe doomed),
  // or an instruction is held; none of these means idle.
  logic        m_req, m_out, m_drop, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc;

  // Memory contents derived from the address so captures can be audited.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic        n_req, n_out, n_drop, n_valid;
    logic [31:0] n_pc, n_instr, n_ipc;
    n_req = m_req; n_out = m_out; n_drop = m_drop; n_valid = m_valid;
    n_pc = m_pc; n_instr = m_instr; n_ipc = m_ipc;
    if (reset) begin
      n_req = 0; n_out = 0; n_drop = 0; n_valid = 0;
      n_pc = RPC; n_instr = 0; n_ipc = 0;
    end else begin
      if (m_req) begin
        if (imem_gnt) begin
          n_req = 0; n_out = 1; n_drop = redirect_valid;
        end
      end else if (m_out) begin
        if (imem_rvalid) begin
          n_out = 0;
          if (m_drop || redirect_valid) begin
            n_req = 1; n_drop = 0;
          end else begin
            n_valid = 1; n_instr = imem_rdata;
            n_ipc = m_pc; n_pc = m_pc + 32'd4;
          end
        end else if (redirect_valid) begin
          n_drop = 1;
        end
      end else if (m_valid) begin
        if (redirect_valid) begin
          n_valid = 0; n_req = 1;
        end else if (instr_ready) begin
          n_valid = 0; n_req = !stall;
        end
      end else if (!stall) begin
        n_req = 1;
      end
      if (redirect_valid) n_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    m_req = n_req; m_out = n_out; m_drop = n_drop; m_valid = n_valid;
    m_pc = n_pc; m_instr = n_instr; m_ipc = n_ipc;
  endtask

  task automatic model_check();
    chk("m_req", 32'(imem_req), 32'(m_req));
    chk("m_addr", imem_addr, m_pc);
    chk("m_pc", pc, m_pc);
    chk("m_pc4", pc_plus4, m_pc + 32'd4);
    chk("m_ivalid", 32'(instr_valid), 32'(m_valid));
    chk("m_instr", instr, m_instr);
    chk("m_ipc", instr_pc, m_ipc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic set(input logic rs, input logic st, input logic rv,
                     input logic [31:0] rpc, input logic g, input logic rvl,
                     input logic [31:0] rd, input logic rdy);
    reset = rs; stall = st; redirect_valid = rv; redirect_pc = rpc;
    imem_gnt = g; imem_rvalid = rvl; imem_rdata = rd; instr_ready = rdy;
  endtask

  logic        mem_out;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    m_req = 0; m_out = 0; m_drop = 0; m_valid = 0;
    m_pc = RPC; m_instr = 0; m_ipc = 0;

    set(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_ivalid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);

    // first fetch
    set(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("ff_req", 32'(imem_req), 32'd1);
    chk("ff_addr", imem_addr, 32'h100);
    set(0, 0, 0, 0, 1, 0, 0, 1); tick();
    chk("ff_wait_req", 32'(imem_req), 32'd0);
    set(0, 0, 0, 0, 0, 1, 32'h0050_0093, 1); tick();
    chk("ff_ivalid", 32'(instr_valid), 32'd1);
    chk("ff_instr", instr, 32'h0050_0093);
    chk("ff_ipc", instr_pc, 32'h100);
    chk("ff_pc", pc, 32'h104);

    // back-pressure
    for (int i = 0; i < 5; i++) begin
      set(0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("bp_instr", instr, 32'h0050_0093);
      chk("bp_ipc", instr_pc, 32'h100);
      chk("bp_pc", pc, 32'h104);
      chk("bp_req", 32'(imem_req), 32'd0);
    end
    set(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("bp_next_req", 32'(imem_req), 32'd1);
    chk("bp_next_addr", imem_addr, 32'h104);
    chk("bp_ivalid", 32'(instr_valid), 32'd0);

    // redirect in WAIT
    set(0, 0, 1, 32'h200, 0, 0, 0, 1); tick();
    chk("rw_addr0", imem_addr, 32'h200);
    set(0, 0, 0, 0, 1, 0, 0, 1); tick();
    set(0, 0, 1, 32'h3000, 0, 0, 0, 1); tick();
    chk("rw_pc", pc, 32'h3000);
    chk("rw_req", 32'(imem_req), 32'd0);
    set(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1); tick();
    chk("rw_ivalid", 32'(instr_valid), 32'd0);
    chk("rw_req2", 32'(imem_req), 32'd1);
    chk("rw_addr", imem_addr, 32'h3000);

    // redirect with grant, then with rvalid
    set(0, 0, 1, 32'h43, 1, 0, 0, 1); tick();
    chk("rg_pc", pc, 32'h40);
    set(0, 0, 0, 0, 0, 1, 32'h1111_1111, 1); tick();
    chk("rg_ivalid", 32'(instr_valid), 32'd0);
    chk("rg_addr", imem_addr, 32'h40);
    chk("rg_req", 32'(imem_req), 32'd1);
    set(0, 0, 0, 0, 1, 0, 0, 1); tick();
    set(0, 0, 1, 32'h40, 0, 1, 32'h2222_2222, 1); tick();
    chk("rr_ivalid", 32'(instr_valid), 32'd0);
    chk("rr_req", 32'(imem_req), 32'd1);
    chk("rr_addr", imem_addr, 32'h40);

    // stall and wrap
    set(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 1); tick();
    set(0, 0, 0, 0, 1, 0, 0, 1); tick();
    set(0, 0, 0, 0, 0, 1, 32'h13, 1); tick();
    chk("sw_pc", pc, 32'hFFFF_FFFC);
    set(0, 1, 0, 0, 0, 0, 0, 1); tick();
    chk("sw_idle_req", 32'(imem_req), 32'd0);
    chk("sw_idle_ivalid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sw_stall_req", 32'(imem_req), 32'd0);
    end
    chk("sw_pc4_wrap", pc_plus4, 32'h0);
    set(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("sw_addr", imem_addr, 32'hFFFF_FFFC);
    chk("sw_req", 32'(imem_req), 32'd1);
    set(0, 0, 0, 0, 1, 0, 0, 1); tick();
    set(0, 0, 0, 0, 0, 1, 32'h73, 1); tick();
    chk("sw_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("sw_wrap_pc", pc, 32'h0);

    // reset mid-WAIT, stray rvalid afterwards
    set(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("rm_addr", imem_addr, 32'h0);
    set(0, 0, 0, 0, 1, 0, 0, 1); tick();
    set(1, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("rm_pc", pc, RPC);
    chk("rm_ivalid", 32'(instr_valid), 32'd0);
    chk("rm_req", 32'(imem_req), 32'd0);
    set(0, 0, 0, 0, 0, 1, 32'h0000_0BAD, 1); tick();
    chk("rm_stray_ivalid", 32'(instr_valid), 32'd0);
    chk("rm_stray_addr", imem_addr, RPC);
    set(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("rm_stray_req", 32'(imem_req), 32'd1);
    chk("rm_stray_ivalid2", 32'(instr_valid), 32'd0);

    // randomized traffic against the model
    set(1, 0, 0, 0, 0, 0, 0, 1); tick();
    mem_out = 0; mem_cnt = 0; mem_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = 0;
      stall = ($urandom % 4) == 0;
      instr_ready = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 8) == 0;
      if ($urandom % 4 == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
      else
        redirect_pc = $urandom;
      imem_rvalid = 0;
      imem_rdata = $urandom;
      if (mem_out) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1;
          imem_rdata = mem_f(mem_addr);
          mem_out = 0;
        end else begin
          mem_cnt--;
        end
      end
      imem_gnt = m_req && ($urandom % 2 == 0);
      if (imem_gnt) begin
        mem_out = 1;
        mem_cnt = $urandom_range(0, 2);
        mem_addr = m_pc;
      end
      tick();
      if (instr_valid === 1'b1)
        chk("rnd_instr_vs_mem", instr, mem_f(instr_pc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Sequencer for the program counter and its +4 incrementer. It issues instruction-memory fetches through a request/grant/response handshake and applies branch/jump redirects at any point in a fetch. It also squashes stale responses and holds each fetched instruction until the decode stage accepts it. It sits between the PC register/incrementer and instruction memory, ahead of decode.

## Interface
- `Width`, 32, PC and address width in bits.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  front-end freeze; blocks new fetch issue.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  Width  redirect target; bits [1:0] ignored (treated as 0).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  Width  fetch address (= PC).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid; exactly one per grant, at least 1 cycle after grant.
- `imem_rdata`  in  32  fetched instruction.
- `instr_valid`  out  1  instruction available to decode.
- `instr`  out  32  held instruction.
- `instr_pc`  out  Width  address of held instruction.
- `instr_ready`  in  1  decode accepts instruction.
- `PC`  out  Width  current PC register.
- `PCPlus4`  out  Width  PC + 4, combinational, modulo 2^Width.

## Operation
- Reset values:
  - PC=RESET_PC.
  - state=IDLE.
  - flush_pending=0.
  - imem_req=0.
  - instr_valid=0, instr=0, instr_pc=0.
- `imem_req` = (state==REQ). `imem_addr` = PC. Both are decoded from registered state only.
- Redirect always loads PC <= {redirect_pc[Width-1:2],2'b00}. It is applied in every state. What else it does depends on the state:
- IDLE:
  - stall=0 -> REQ.
  - stall=1 -> stay in IDLE.
  - Redirect updates PC only.
- REQ:
  - Hold imem_req=1 until imem_gnt.
  - The address may change before grant, but only via redirect.
  - gnt=1 -> WAIT.
  - gnt=1 with a redirect in the same cycle -> WAIT, flush_pending<=1 (the granted fetch used the old PC).
  - stall is ignored once in REQ.
- WAIT:
  - imem_req=0.
  - redirect_valid without rvalid sets flush_pending<=1.
  - rvalid with flush_pending=1 or redirect_valid=1: discard data, flush_pending<=0, go to REQ. PC already holds or now takes the target.
  - rvalid, clean: instr<=imem_rdata, instr_pc<=PC, instr_valid<=1, PC<=PCPlus4, go to HOLD.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable.
  - Redirect has priority over instr_ready: instr_valid<=0, go to REQ (the held instruction is dropped).
  - Otherwise, on instr_ready: instr_valid<=0, then REQ if stall=0, else IDLE.
- PC increment wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. There is no exception on wrap.
- Reset asserted in any state, including WAIT with a response outstanding, returns everything to reset values next edge.
  - A late rvalid arriving in IDLE/REQ/HOLD is ignored.

## Timing
- First imem_req: 1 cycle after reset deasserts, if stall=0.
- Grant to capture: instr_valid rises on the edge after the rvalid cycle.
- Steady-state minimum with gnt same cycle, rvalid next cycle and instr_ready=1: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect-to-request latency:
  - 1 cycle from IDLE/HOLD.
  - 0 extra cycles in REQ (the address updates next cycle).
  - From WAIT: 1 cycle after the outstanding rvalid.
- No combinational path from any input to imem_req, instr_valid or instr. Only PCPlus4 is combinational, and only from PC.

## Test plan
- Reset/first fetch: RESET_PC=0x100; release reset, gnt and rvalid immediate, rdata=0x00500093, ready=1 -> imem_addr=0x100 one cycle after reset; instr_valid with instr=0x00500093, instr_pc=0x100; PC=0x104.
- Back-pressure: instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc and PC stable, no imem_req; ready=1 -> next request at 0x104.
- Redirect in WAIT: fetch 0x200 granted, redirect_pc=0x3000 before rvalid -> response discarded, instr_valid stays 0, next imem_addr=0x3000.
- Redirect with grant same cycle and with rvalid same cycle: target 0x40 (with 0x43 also driven once to check bits [1:0] are ignored) -> both responses discarded, fetch at 0x40.
- Stall and wrap: PC=0xFFFF_FFFC, stall=1 after accept -> IDLE, no request; stall=0 -> fetch 0xFFFF_FFFC, then PC=0x0.
- Reset mid-WAIT: assert reset with rvalid due next cycle -> PC=RESET_PC, instr_valid=0, stray rvalid ignored.
